// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: accepts MD requests, stalls while the unit is occupied.
// Optional watchdog on a stuck md_busy is compiled in with `define MD_TIMEOUT_EN.
module md_issue_ctrl #(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic              req_flush,
   output logic              stall,
   output logic [DATA_W-1:0] rd_data,
   output logic              md_done,
   output logic              md_start,
   output logic [2:0]        md_op,
   output logic [DATA_W-1:0] md_src1,
   output logic [DATA_W-1:0] md_src2,
   input  logic              md_busy,
   input  logic [DATA_W-1:0] md_out,
   output logic              md_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

   localparam logic [2:0] OP_DIVU = 3'd3;
   localparam logic [2:0] OP_MFHI = 3'd6;

   state_t state, state_nxt;
   logic   occupied;
   logic   accept;
   logic   done_nxt;
   logic   timeout_hit;

   // LAUNCH covers the cycle between md_start and md_busy rising
   assign occupied = (state != IDLE) | md_busy;
   assign accept   = req_valid & ~req_flush & ~occupied;
   assign stall    = req_valid & ~req_flush & occupied;

   // Idle md_op is a read code so the unit never sees a stray hi/lo write
   always_comb begin
      md_start = 1'b0;
      md_op    = OP_MFHI;
      md_src1  = '0;
      md_src2  = '0;
      rd_data  = '0;
      if (accept) begin
         md_op    = req_op;
         md_src1  = req_a;
         md_src2  = req_b;
         md_start = (req_op <= OP_DIVU);
         if (req_op >= OP_MFHI)
            rd_data = md_out;
      end
   end

`ifdef MD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt, cnt_nxt;

   assign timeout_hit = (state == WAIT) && md_busy && (cnt == CNT_W'(TIMEOUT_CYC));

   always_comb begin
      cnt_nxt = cnt;
      case (state)
         LAUNCH:  cnt_nxt = '0;
         WAIT:    cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         md_timeout <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (timeout_hit)
            md_timeout <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign md_timeout  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (req_op <= OP_DIVU))
               state_nxt = LAUNCH;
         end
         LAUNCH: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (!md_busy) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         md_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         md_done <= done_nxt;
      end
   end

endmodule
